muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
//  Sits directly downstream of reg_file: consumes rs_data/rt_data for
//  MULT/MULTU/DIV/DIVU and MTHI/MTLO, and supplies hi/lo to the MFHI/MFLO
//  writeback path. The pipeline stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; even, >=4. Iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      launch op; sampled only in IDLE
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data   in   WIDTH  multiplicand / dividend
//  rt_data   in   WIDTH  multiplier / divisor
//  mthi      in   1      hi <= rs_data (IDLE only)
//  mtlo      in   1      lo <= rs_data (IDLE only)
//  busy      out  1      state != IDLE
//  done      out  1      one-cycle pulse; hi/lo hold the new result
//  hi        out  WIDTH  HI register (product upper half / remainder)
//  lo        out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset (any state): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0.
//    An in-flight result is discarded.
//  - FSM states: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: when start=1, latch op and operand magnitudes (signed ops use
//    two's-complement abs), record sign flags, clear counter, go to CALC.
//    CALC: one shift-add (multiply) or restoring shift-subtract (divide)
//    iteration per cycle. Stay for WIDTH cycles (counter 0..WIDTH-1),
//    then go to FIX.
//    FIX: apply sign fixup, write hi/lo, done<=1, go to IDLE.
//  - Timing: start accepted at edge N. busy=1 after edges N..N+WIDTH, i.e.
//    for WIDTH+1 cycles. hi/lo update and done=1 after edge N+WIDTH+1.
//    done clears at the next edge. A new start is accepted in the same
//    cycle that done=1.
//  - Multiply: {hi,lo} = full 2*WIDTH product. MULT negates the product
//    when sign(rs) != sign(rt).
//  - Divide: lo = quotient, hi = remainder, truncating toward zero.
//    Signed: quotient negated if signs differ; remainder takes dividend sign.
//    0x80000000 / -1 (signed): lo=0x80000000, hi=0 (wraps, no trap).
//  - Divide by zero (DIV or DIVU): full latency, no sign fixup;
//    hi = rs_data as sampled, lo = all ones.
//  - start while busy: ignored (no queue).
//  - mthi/mtlo while busy: ignored.
//  - start together with mthi/mtlo in IDLE: start wins; the moves are dropped.
//  - mthi and mtlo in the same cycle: both write rs_data.
//  - hi/lo hold their value whenever no write occurs. They are not modified
//    during CALC; partial results live in internal shadow registers.
// STRUCTURE
//  - Shared package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV,
//    OP_DIVU), state encodings (S_IDLE, S_CALC, S_FIX), counter width
//    $clog2(WIDTH).
//  - One natural sub-module, muldiv_datapath: accumulator/shift registers
//    plus the add/subtract step. The FSM, counter and HI/LO registers stay
//    in the top module.
// TESTING
//  1 Reset mid-CALC (10 cycles after start) -> next cycle busy=0, done=0,
//    hi=lo=0; no done pulse follows.
//  2 MULTU 0xFFFFFFFF*2 -> done 33 cycles after the start edge;
//    hi=0x00000001, lo=0xFFFFFFFE. MULT -3*7 -> hi=0xFFFFFFFF,
//    lo=0xFFFFFFEB.
//  3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 DIVU 100/0 and DIV -5/0 -> lo=0xFFFFFFFF; hi=0x64 and 0xFFFFFFFB
//    respectively; latency 33 cycles.
//  5 During busy: start with other operands, plus mthi with rs=0xAAAA5555
//    -> both ignored; original result delivered. After done: mthi then
//    mtlo -> hi/lo=0xAAAA5555 on the next edge.
//  6 start+mtlo same IDLE cycle -> lo unchanged until done. Back-to-back
//    start in the done cycle -> second result 33 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
// Op codes match the 2-bit op port; counter width is derived from WIDTH.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiply / restoring shift-subtract divide on magnitudes.
// After WIDTH steps: multiply {acc,quo} = product; divide quo = quotient, acc = remainder.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    div_trial = {acc, quo[WIDTH-1]};
    div_ok    = (div_trial >= {1'b0, m});
    // When the trial subtract succeeds the difference is below 2^WIDTH, so the low bits suffice.
    div_diff  = div_trial[WIDTH-1:0] - m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      quo <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      quo <= a_mag;
      m   <= b_mag;
    end else if (step) begin
      if (is_div) begin
        acc <= div_ok ? div_diff : div_trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], div_ok};
      end else begin
        acc <= mul_sum[WIDTH:1];
        quo <= {mul_sum[0], quo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Start to done takes WIDTH+1 edges; hi/lo change only on completion or an idle move.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, is_signed_q, neg_q, rs_neg_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             load, step, fix;
  op_t              op_in;
  logic             in_signed, in_div, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] acc, quo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in     = op_t'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign rs_neg    = in_signed & rs_data[WIDTH-1];
  assign rt_neg    = in_signed & rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        fix     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divide by zero leaves remainder = |rs|; restoring the dividend sign yields rs exactly.
  always_comb begin
    prod     = {acc, quo};
    prod_fix = (is_signed_q && neg_q) ? (~prod + 1'b1) : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = rs_neg_q ? (~acc + 1'b1) : acc;
      if (div0_q)                   res_lo = '1;
      else if (is_signed_q && neg_q) res_lo = ~quo + 1'b1;
      else                           res_lo = quo;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (load ? in_div : is_div_q),
    .a_mag  (rs_mag),
    .b_mag  (rt_mag),
    .acc    (acc),
    .quo    (quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_q       <= 1'b0;
      rs_neg_q    <= 1'b0;
      div0_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fix;
      if (load) begin
        cnt_q       <= '0;
        is_div_q    <= in_div;
        is_signed_q <= in_signed;
        neg_q       <= rs_neg ^ rt_neg;
        rs_neg_q    <= rs_neg;
        div0_q      <= (rt_data == '0);
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fix) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == S_IDLE && !start) begin
        if (mthi) hi_q <= rs_data;
        if (mtlo) lo_q <= rs_data;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc;
  logic [W-1:0] exp_hi, exp_lo, pre_hi, pre_lo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mtlo);
    @(negedge clk);
    pre_hi = hi;
    pre_lo = lo;
    {exp_hi, exp_lo} = model(o, a, b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    mtlo    = with_mtlo;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    mtlo  = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    bit seen = 0;
    bit changed = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
      else if (hi !== pre_hi || lo !== pre_lo) changed = 1;
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_latency"}, cyc - start_cyc, 33);
    check({tag, "_hold"}, changed, 0);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    int npulse;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    launch(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("multu_max", 32'h0000_0001, 32'hFFFF_FFFE);
    launch(2'b00, -32'sd3, 32'd7, 1'b0);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    launch(2'b10, -32'sd7, 32'd2, 1'b0);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    launch(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done("divu", 32'd2, 32'd14);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 32'd0, 32'h8000_0000);
    launch(2'b11, 32'd100, 32'd0, 1'b0);
    wait_done("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF);
    launch(2'b10, -32'sd5, 32'd0, 1'b0);
    wait_done("div_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Reset in the middle of an operation discards it.
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    npulse = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) npulse++;
    end
    check("midrst_no_done", npulse, 0);

    // Start and mthi while busy are both ignored.
    launch(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'hAAAA_5555; rt_data = 32'd3; mthi = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0;
    check("busy_mthi_ignored", hi, pre_hi);
    wait_done("busy_ign", 32'd2, 32'd14);

    @(negedge clk);
    mthi = 1'b1; rs_data = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hAAAA_5555);
    check("mthi_lo_kept", lo, 32'd14);
    @(negedge clk);
    mtlo = 1'b1;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hAAAA_5555);

    // Start wins over mtlo; then a back-to-back start in the done cycle.
    launch(2'b01, 32'd5, 32'd6, 1'b1);
    check("start_mtlo_lo", lo, 32'hAAAA_5555);
    wait_done("start_mtlo", 32'd0, 32'd30);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("b2b", 32'd0, 32'h8000_0000);

    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      launch(ro, ra, rb, 1'b0);
      wait_done("rand", exp_hi, exp_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
